// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: owns the fetch PC, handshakes with instruction memory,
// applies hazard stalls and keeps D-stage redirects alive while fetch is blocked.
module pc_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_stall,
    input  logic        c_redirect,
    input  logic [31:0] v_target,
    input  logic        i_ack,
    input  logic [31:0] i_rdata,
    output logic        i_req,
    output logic [31:0] i_addr,
    output logic [31:0] a_PC,
    output logic        c_fd_we,
    output logic        c_fd_valid,
    output logic [31:0] v_instr,
    output logic [31:0] v_pc_F
);

    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic        r_pend_v;
    logic [31:0] r_pend_tgt;

    logic [31:0] w_tgt;
    logic [31:0] w_nxt;
    logic        w_pc_upd;
    logic        w_buf_ld;

    // Targets are word aligned; low bits from D are ignored.
    assign w_tgt = v_target & ~32'h3;
    assign w_nxt = c_redirect ? w_tgt : r_pend_v ? r_pend_tgt : r_pc + 32'd4;

    assign a_PC   = r_pc;
    assign i_addr = r_pc;
    assign v_pc_F = r_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_upd    = 1'b0;
        w_buf_ld    = 1'b0;
        i_req       = 1'b0;
        c_fd_we     = 1'b0;
        c_fd_valid  = 1'b0;
        v_instr     = 32'd0;
        if (!reset) begin
            // Flush F/D with a bubble while reset is held.
            c_fd_we = 1'b1;
        end else begin
            case (r_state)
                S_REQ: begin
                    i_req = 1'b1;
                    if (i_ack && !c_stall) begin
                        c_fd_we    = 1'b1;
                        c_fd_valid = 1'b1;
                        v_instr    = i_rdata;
                        w_pc_upd   = 1'b1;
                    end else if (i_ack && c_stall) begin
                        w_buf_ld    = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else if (!c_stall) begin
                        c_fd_we = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!c_stall) begin
                        c_fd_we     = 1'b1;
                        c_fd_valid  = 1'b1;
                        v_instr     = r_buf;
                        w_pc_upd    = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_buf      <= 32'd0;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_buf_ld)
                r_buf <= i_rdata;
            if (w_pc_upd) begin
                r_pc     <= w_nxt;
                r_pend_v <= 1'b0;
            end else if (c_redirect) begin
                // Latest redirect wins until the next delivery consumes it.
                r_pend_v   <= 1'b1;
                r_pend_tgt <= w_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq: memory word for address A is A ^ 32'hA5A5_5A5A.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_stall;
    logic        c_redirect;
    logic [31:0] v_target;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] a_PC;
    logic        c_fd_we;
    logic        c_fd_valid;
    logic [31:0] v_instr;
    logic [31:0] v_pc_F;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign i_rdata = memw(i_addr);

    pc_seq #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .c_stall(c_stall), .c_redirect(c_redirect),
        .v_target(v_target), .i_ack(i_ack), .i_rdata(i_rdata), .i_req(i_req),
        .i_addr(i_addr), .a_PC(a_PC), .c_fd_we(c_fd_we), .c_fd_valid(c_fd_valid),
        .v_instr(v_instr), .v_pc_F(v_pc_F)
    );

    // Advance to just after the next rising edge; inputs are then driven mid-cycle.
    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic stl, input logic ack,
                         input logic rdr, input logic [31:0] tgt);
        reset = rst; c_stall = stl; i_ack = ack; c_redirect = rdr; v_target = tgt;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        edge_wait();
        n_chk++; if (a_PC !== 32'h3000) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", a_PC, 32'h3000); end
        n_chk++; if ({i_req, c_fd_we, c_fd_valid} !== 3'b010) begin n_bad++; $display("FAIL reset_ctl got=%b exp=010", {i_req, c_fd_we, c_fd_valid}); end
        n_chk++; if (v_instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr got=%h exp=0", v_instr); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if (i_req !== 1'b1 || i_addr !== 32'h3000) begin n_bad++; $display("FAIL first_req got=%b/%h exp=1/00003000", i_req, i_addr); end
    endtask

    task automatic test_seq();
        logic [31:0] pc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pc = 32'h3000 + 32'(4 * k);
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
            n_chk++; if (a_PC !== pc || v_pc_F !== pc || i_addr !== pc) begin n_bad++; $display("FAIL seq_pc%0d got=%h exp=%h", k, a_PC, pc); end
            n_chk++; if ({c_fd_we, c_fd_valid} !== 2'b11 || v_instr !== memw(pc)) begin n_bad++; $display("FAIL seq_instr%0d got=%b%b/%h exp=11/%h", k, c_fd_we, c_fd_valid, v_instr, memw(pc)); end
            edge_wait();
        end
        n_chk++; if (a_PC !== 32'h300C) begin n_bad++; $display("FAIL seq_end got=%h exp=0000300c", a_PC); end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0); edge_wait();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0); edge_wait();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h3100);
        n_chk++; if (c_fd_valid !== 1'b1 || v_instr !== memw(32'h3008)) begin n_bad++; $display("FAIL rdr_slot got=%b/%h exp=1/%h", c_fd_valid, v_instr, memw(32'h3008)); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'h3100) begin n_bad++; $display("FAIL rdr_pc got=%h exp=00003100", a_PC); end
        n_chk++; if (dut.r_pend_v !== 1'b0) begin n_bad++; $display("FAIL rdr_pend got=%b exp=0", dut.r_pend_v); end
    endtask

    task automatic test_latency();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0); edge_wait();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0); edge_wait();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, (k == 0), 32'h3200);
            n_chk++; if ({i_req, c_fd_we, c_fd_valid} !== 3'b110 || a_PC !== 32'h3008) begin n_bad++; $display("FAIL lat_bubble%0d got=%b%b%b/%h exp=110/00003008", k, i_req, c_fd_we, c_fd_valid, a_PC); end
            edge_wait();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        n_chk++; if (dut.r_pend_v !== 1'b1) begin n_bad++; $display("FAIL lat_pend got=%b exp=1", dut.r_pend_v); end
        n_chk++; if (c_fd_valid !== 1'b1 || v_instr !== memw(32'h3008)) begin n_bad++; $display("FAIL lat_deliver got=%b/%h exp=1/%h", c_fd_valid, v_instr, memw(32'h3008)); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'h3200) begin n_bad++; $display("FAIL lat_pc got=%h exp=00003200", a_PC); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        n_chk++; if (c_fd_we !== 1'b0) begin n_bad++; $display("FAIL hold_ackstall_we got=%b exp=0", c_fd_we); end
        edge_wait();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        n_chk++; if (i_req !== 1'b0 || c_fd_we !== 1'b0) begin n_bad++; $display("FAIL hold_idle got=%b%b exp=00", i_req, c_fd_we); end
        edge_wait();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h3300);
        n_chk++; if (i_req !== 1'b0 || c_fd_we !== 1'b0 || a_PC !== 32'h3000) begin n_bad++; $display("FAIL hold_rdr got=%b%b/%h exp=00/00003000", i_req, c_fd_we, a_PC); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if ({c_fd_we, c_fd_valid} !== 2'b11 || v_instr !== memw(32'h3000)) begin n_bad++; $display("FAIL hold_deliver got=%b%b/%h exp=11/%h", c_fd_we, c_fd_valid, v_instr, memw(32'h3000)); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'h3300 || i_req !== 1'b1) begin n_bad++; $display("FAIL hold_pc got=%h/%b exp=00003300/1", a_PC, i_req); end
        n_chk++; if (c_fd_valid !== 1'b0) begin n_bad++; $display("FAIL hold_once got=%b exp=0", c_fd_valid); end
    endtask

    task automatic test_two_redirects();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h3400); edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h3500); edge_wait();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        n_chk++; if (v_instr !== memw(32'h3000)) begin n_bad++; $display("FAIL two_slot got=%h exp=%h", v_instr, memw(32'h3000)); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'h3500) begin n_bad++; $display("FAIL two_pc got=%h exp=00003500", a_PC); end
    endtask

    task automatic test_reset_hold();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0); edge_wait();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h3600); edge_wait();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        n_chk++; if ({i_req, c_fd_we, c_fd_valid} !== 3'b010 || v_instr !== 32'd0) begin n_bad++; $display("FAIL rsthold_flush got=%b%b%b/%h exp=010/0", i_req, c_fd_we, c_fd_valid, v_instr); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'h3000 || dut.r_pend_v !== 1'b0 || i_req !== 1'b1) begin n_bad++; $display("FAIL rsthold_state got=%h/%b/%b exp=00003000/0/1", a_PC, dut.r_pend_v, i_req); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF); edge_wait();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_align got=%h exp=fffffffc", a_PC); end
        n_chk++; if (v_instr !== memw(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_instr got=%h exp=%h", v_instr, memw(32'hFFFF_FFFC)); end
        edge_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_chk++; if (a_PC !== 32'd0) begin n_bad++; $display("FAIL wrap_pc got=%h exp=00000000", a_PC); end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        test_reset();
        test_seq();
        test_redirect();
        test_latency();
        test_stall_hold();
        test_two_redirects();
        test_reset_hold();
        test_wrap();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
